// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII transmit encoder.
package rgmii_pkg;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10
  } speed_e;

  localparam int DIV_100_DEF = 5;
  localparam int DIV_10_DEF  = 50;
  localparam int NIB_W       = 4;
  localparam int BYTE_W      = 8;

  // The unused code 2'b11 folds into gigabit.
  function automatic speed_e decode_speed(input logic [1:0] s);
    case (s)
      2'b00:   decode_speed = SPEED_10;
      2'b01:   decode_speed = SPEED_100;
      default: decode_speed = SPEED_1000;
    endcase
  endfunction

endpackage

// File: rtl/rgmii_tx_clk_div.sv
// TXC divider for 10/100 operation: nibble counter, phase, TXC half-cycle
// pattern and the registered MAC byte strobe. Held idle in gigabit mode.
module rgmii_tx_clk_div
  import rgmii_pkg::*;
#(
  parameter int DIV_100 = DIV_100_DEF,
  parameter int DIV_10  = DIV_10_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  speed_e speed_i,
  input  logic   clr_i,
  output logic   strobe_o,
  output logic   txc_d1_o,
  output logic   txc_d2_o,
  output logic   txc1_nx_o,
  output logic   txc2_nx_o,
  output logic   cnt_zero_o
);

  localparam int DIV_MAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
  localparam int CNT_W   = $clog2(DIV_MAX);

  localparam logic [CNT_W-1:0] D100_M1 = CNT_W'(DIV_100 - 1);
  localparam logic [CNT_W-1:0] D100_HI = CNT_W'((DIV_100 + 1) / 2);
  localparam logic [CNT_W-1:0] D100_LO = CNT_W'(DIV_100 / 2);
  localparam logic [CNT_W-1:0] D10_M1  = CNT_W'(DIV_10 - 1);
  localparam logic [CNT_W-1:0] D10_HI  = CNT_W'((DIV_10 + 1) / 2);
  localparam logic [CNT_W-1:0] D10_LO  = CNT_W'(DIV_10 / 2);

  generate
    if (DIV_100 < 2 || DIV_10 < 2) begin : g_bad_div
      $error("rgmii_tx_clk_div: DIV_100 and DIV_10 must both be >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d, div_m1, half_hi, half_lo;
  logic             phase_q, phase_d, fast;

  always_comb begin
    fast    = (speed_i == SPEED_1000);
    div_m1  = D100_M1;
    half_hi = D100_HI;
    half_lo = D100_LO;
    if (speed_i == SPEED_10) begin
      div_m1  = D10_M1;
      half_hi = D10_HI;
      half_lo = D10_LO;
    end

    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i || fast) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == div_m1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Odd dividers split the middle cycle across the two DDR halves.
    txc1_nx_o  = fast | (cnt_d < half_hi);
    txc2_nx_o  = ~fast & (cnt_d < half_lo);
    cnt_zero_o = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      strobe_o <= 1'b0;
      txc_d1_o <= 1'b0;
      txc_d2_o <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      strobe_o <= fast | ((cnt_d == div_m1) & phase_d);
      txc_d1_o <= txc1_nx_o;
      txc_d2_o <= txc2_nx_o;
    end
  end

endmodule

// File: rtl/rgmii_tx_encoder.sv
// RGMII transmit encoder: GMII bytes to DDR half-words for TXD/TX_CTL/TXC.
// Define RGMII_TX_ER_EN to encode gmii_tx_er onto TX_CTL; otherwise it is ignored.
module rgmii_tx_encoder
  import rgmii_pkg::*;
#(
  parameter int DIV_100 = DIV_100_DEF,
  parameter int DIV_10  = DIV_10_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        speed,
  input  logic [BYTE_W-1:0] gmii_txd,
  input  logic              gmii_tx_en,
  input  logic              gmii_tx_er,
  output logic              gmii_clk_en,
  output logic [NIB_W-1:0]  txd_d1,
  output logic [NIB_W-1:0]  txd_d2,
  output logic              txctl_d1,
  output logic              txctl_d2,
  output logic              txc_d1,
  output logic              txc_d2
);

  speed_e            speed_q, speed_d, speed_in;
  logic              load, clr, fast, take;
  logic              txc1_nx, txc2_nx, cnt_zero;
  logic [BYTE_W-1:0] byte_in, cap_q, cap_d;
  logic              er_in, en_q, en_d, er_q, er_d;
  logic [NIB_W-1:0]  txd1_q, txd1_d, txd2_q, txd2_d;
  logic              ctl1_q, ctl1_d, ctl2_q, ctl2_d;

`ifdef RGMII_TX_ER_EN
  assign er_in = gmii_tx_en & gmii_tx_er;
`else
  logic unused_tx_er;
  assign unused_tx_er = gmii_tx_er;
  assign er_in        = 1'b0;
`endif

  rgmii_tx_clk_div #(
    .DIV_100 (DIV_100),
    .DIV_10  (DIV_10)
  ) u_clk_div (
    .clk        (clk),
    .rst        (rst),
    .speed_i    (speed_d),
    .clr_i      (clr),
    .strobe_o   (gmii_clk_en),
    .txc_d1_o   (txc_d1),
    .txc_d2_o   (txc_d2),
    .txc1_nx_o  (txc1_nx),
    .txc2_nx_o  (txc2_nx),
    .cnt_zero_o (cnt_zero)
  );

  always_comb begin
    speed_in = decode_speed(speed);
    // Idle bytes are zeroed so TXD reads 0 outside a frame.
    byte_in  = gmii_tx_en ? gmii_txd : '0;
    load     = gmii_clk_en & ~gmii_tx_en;
    speed_d  = load ? speed_in : speed_q;
    clr      = load & (speed_in != speed_q);
    fast     = (speed_d == SPEED_1000);
    take     = fast | gmii_clk_en;

    cap_d = take ? byte_in : cap_q;
    en_d  = take ? gmii_tx_en : en_q;
    er_d  = take ? er_in : er_q;

    txd1_d = txd1_q;
    txd2_d = txd2_q;
    if (fast) begin
      txd1_d = byte_in[3:0];
      txd2_d = byte_in[7:4];
    end else if (gmii_clk_en) begin
      txd1_d = byte_in[3:0];
      txd2_d = byte_in[3:0];
    end else if (cnt_zero) begin
      txd1_d = cap_q[7:4];
      txd2_d = cap_q[7:4];
    end

    ctl1_d = txc1_nx ? en_d : (en_d ^ er_d);
    ctl2_d = txc2_nx ? en_d : (en_d ^ er_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q <= SPEED_1000;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      txd1_q  <= '0;
      txd2_q  <= '0;
      ctl1_q  <= 1'b0;
      ctl2_q  <= 1'b0;
    end else begin
      speed_q <= speed_d;
      en_q    <= en_d;
      er_q    <= er_d;
      txd1_q  <= txd1_d;
      txd2_q  <= txd2_d;
      ctl1_q  <= ctl1_d;
      ctl2_q  <= ctl2_d;
    end
  end

  // Byte buffer only matters after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
  end

  assign txd_d1   = txd1_q;
  assign txd_d2   = txd2_q;
  assign txctl_d1 = ctl1_q;
  assign txctl_d2 = ctl2_q;

endmodule

// File: tb/tb_rgmii_tx_encoder.sv
// Directed bench for rgmii_tx_encoder: gigabit vector table plus 100/10 Mb/s,
// mid-frame speed change and asynchronous reset sequences.
module tb_rgmii_tx_encoder;

`ifdef RGMII_TX_ER_EN
  localparam bit ER_ON = 1'b1;
`else
  localparam bit ER_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] speed = 2'b10;
  logic [7:0] gmii_txd = 8'h00;
  logic       gmii_tx_en = 1'b0;
  logic       gmii_tx_er = 1'b0;
  logic       gmii_clk_en;
  logic [3:0] txd_d1, txd_d2;
  logic       txctl_d1, txctl_d2, txc_d1, txc_d2;

  int checks = 0;
  int errors = 0;

  rgmii_tx_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .speed       (speed),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .gmii_clk_en (gmii_clk_en),
    .txd_d1      (txd_d1),
    .txd_d2      (txd_d2),
    .txctl_d1    (txctl_d1),
    .txctl_d2    (txctl_d2),
    .txc_d1      (txc_d1),
    .txc_d2      (txc_d2)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [1:0] spd;
    logic [7:0] txd;
    logic       en;
    logic       er;
    logic [3:0] d1;
    logic [3:0] d2;
    logic       l1;
    logic       l2;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [12:0] pk(input logic ce, input logic [3:0] d1, input logic [3:0] d2,
                                     input logic l1, input logic l2, input logic c1, input logic c2);
    pk = {ce, d1, d2, l1, l2, c1, c2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [12:0] exp);
    logic [12:0] act;
    act = {gmii_clk_en, txd_d1, txd_d2, txctl_d1, txctl_d2, txc_d1, txc_d2};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got={ce,d1,d2,l1,l2,c1,c2}=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic wait_strobe(input int bound, input string nm);
    int n;
    n = 0;
    while (gmii_clk_en !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (gmii_clk_en !== 1'b1) begin
      errors++;
      $display("FAIL %s strobe not seen within %0d cycles (got %b want 1)", nm, bound, gmii_clk_en);
    end
  endtask

  // Checks one 10/100 byte, 2*div cycles, starting on the cycle after capture.
  task automatic run_byte(input int div, input logic [7:0] b, input logic erb, input string nm);
    int cnt;
    logic c1, c2, l1, l2, ce;
    logic [3:0] nib;
    for (int k = 0; k < 2 * div; k++) begin
      cnt = k % div;
      c1  = (cnt < (div + 1) / 2);
      c2  = (cnt < div / 2);
      nib = (k < div) ? b[3:0] : b[7:4];
      l1  = c1 ? 1'b1 : ~erb;
      l2  = c2 ? 1'b1 : ~erb;
      ce  = (k == 2 * div - 1);
      chk($sformatf("%s_k%0d", nm, k), pk(ce, nib, nib, l1, l2, c1, c2));
      if (k != 2 * div - 1) tick();
    end
  endtask

  initial begin
    vecs[0] = '{2'b10, 8'hA5, 1'b1, 1'b0, 4'h5, 4'hA, 1'b1, 1'b1};
    vecs[1] = '{2'b10, 8'h3C, 1'b1, 1'b0, 4'hC, 4'h3, 1'b1, 1'b1};
    vecs[2] = '{2'b10, 8'hFF, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, ~ER_ON};
    vecs[3] = '{2'b10, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[4] = '{2'b10, 8'h5A, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 8'h5A, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[6] = '{2'b11, 8'h81, 1'b1, 1'b0, 4'h1, 4'h8, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset", 13'h0);
    rst = 1'b0;

    // Gigabit: one-cycle latency, strobe constant, TXC 1/0.
    for (int i = 0; i < 7; i++) begin
      speed      = vecs[i].spd;
      gmii_txd   = vecs[i].txd;
      gmii_tx_en = vecs[i].en;
      gmii_tx_er = vecs[i].er;
      tick();
      chk($sformatf("g1000_v%0d", i),
          pk(1'b1, vecs[i].d1, vecs[i].d2, vecs[i].l1, vecs[i].l2, 1'b1, 1'b0));
    end

    // Switch to 100 while idle.
    speed = 2'b01; gmii_txd = 8'h00; gmii_tx_en = 1'b0; gmii_tx_er = 1'b0;
    tick();
    chk("to100", pk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1));
    wait_strobe(20, "ws100");

    // Two bytes with a gigabit request pending mid-frame.
    speed = 2'b10; gmii_txd = 8'h3C; gmii_tx_en = 1'b1;
    tick();
    run_byte(5, 8'h3C, 1'b0, "b100a");
    gmii_txd = 8'h96;
    tick();
    run_byte(5, 8'h96, 1'b0, "b100b");
    gmii_txd = 8'h00; gmii_tx_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("back1000_%0d", i), pk(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    end

    // 10 Mb/s with TX_ER asserted on the byte.
    speed = 2'b00;
    tick();
    chk("to10", pk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1));
    wait_strobe(200, "ws10");
    gmii_txd = 8'hE7; gmii_tx_en = 1'b1; gmii_tx_er = 1'b1;
    tick();
    run_byte(50, 8'hE7, ER_ON, "b10");
    gmii_txd = 8'h00; gmii_tx_en = 1'b0; gmii_tx_er = 1'b0;
    tick();
    chk("idle10", pk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1));

    // Reset during the high nibble at 100.
    speed = 2'b01;
    wait_strobe(200, "ws10b");
    tick();
    wait_strobe(20, "ws100b");
    gmii_txd = 8'hA5; gmii_tx_en = 1'b1;
    tick();
    repeat (6) tick();
    chk("pre_rst", pk(1'b0, 4'hA, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1));
    #1 rst = 1'b1;
    #1;
    chk("async_rst", 13'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; speed = 2'b01; gmii_txd = 8'h5A; gmii_tx_en = 1'b1; gmii_tx_er = 1'b0;
    tick();
    chk("post_rst0", pk(1'b1, 4'hA, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0));
    tick();
    chk("post_rst1", pk(1'b1, 4'hA, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
